// File: rtl/kernal_params_loader_pkg.sv
// Shared conv definitions: loader FSM encoding, kernel element count and a ceil-log2 helper.
// Used at elaboration only; no logic of its own.
package kernal_params_loader_pkg;

    localparam int KERNAL_ELEM_N = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

    // Bits needed to hold values 0..n-1 (minimum 1).
    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((32'sd1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/kernal_param_packer.sv
// Regroups lane_n-wide parameter beats into 9-parameter kernels; kern_vld/kern_dat are combinational
// on the accepted beat (0 cycles), and the packer never stalls its producer.
module kernal_param_packer
    import kernal_params_loader_pkg::*;
#(
    parameter int param_width = 16,
    parameter int lane_n      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr,
    input  logic                                 in_vld,
    input  logic [lane_n*param_width-1:0]        in_dat,
    output logic                                 kern_vld,
    output logic [KERNAL_ELEM_N*param_width-1:0] kern_dat
);

    localparam int MW = (KERNAL_ELEM_N + lane_n - 1) * param_width;
    localparam int CW = clogb2(KERNAL_ELEM_N + lane_n);

    logic [MW-1:0] pack_q;
    logic [MW-1:0] shifted_in;
    logic [MW-1:0] merged;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_sum;

    // New params land directly above the ones already held; bits above cnt_q are always zero.
    always_comb begin
        shifted_in = MW'(in_dat) << (int'(cnt_q) * param_width);
        merged     = pack_q | shifted_in;
        cnt_sum    = cnt_q + CW'(lane_n);
        kern_vld   = in_vld && (cnt_sum >= CW'(KERNAL_ELEM_N));
        kern_dat   = merged[KERNAL_ELEM_N*param_width-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q <= '0;
            cnt_q  <= '0;
        end else if (clr) begin
            pack_q <= '0;
            cnt_q  <= '0;
        end else if (in_vld) begin
            if (kern_vld) begin
                pack_q <= merged >> (KERNAL_ELEM_N * param_width);
                cnt_q  <= cnt_sum - CW'(KERNAL_ELEM_N);
            end else begin
                pack_q <= merged;
                cnt_q  <= cnt_sum;
            end
        end
    end

endmodule

// File: rtl/kernal_params_loader.sv
// Loads chn_n packed 3x3 kernels from an AXIS stream into the kernel buffer at addresses 0..chn_n-1.
// One registered write per kernel, 1 cycle after its completing beat; s_axis_ready never drops in LOAD/DRAIN.
module kernal_params_loader
    import kernal_params_loader_pkg::*;
#(
    parameter int kernal_param_data_width = 16,
    parameter int in_stream_width         = 64,
    parameter int max_feature_map_chn_n   = 512,
    parameter int simulation_delay        = 1
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             s_cmd_valid,
    output logic                                             s_cmd_ready,
    input  logic [15:0]                                      s_cmd_chn_n_sub1,
    input  logic [in_stream_width-1:0]                       s_axis_data,
    input  logic                                             s_axis_valid,
    output logic                                             s_axis_ready,
    input  logic                                             s_axis_last,
    output logic                                             buffer_wen,
    output logic [15:0]                                      buffer_waddr,
    output logic [KERNAL_ELEM_N*kernal_param_data_width-1:0] buffer_din,
    output logic                                             done,
    output logic                                             err_short,
    output logic                                             err_ovf
);

    localparam int          W     = kernal_param_data_width;
    localparam int          P     = in_stream_width / kernal_param_data_width;
    localparam logic [16:0] MAX_K = 17'(max_feature_map_chn_n);

    if (!(P == 1 || P == 2 || P == 4 || P == 8) || (P * W != in_stream_width) || (simulation_delay < 0))
    begin : g_bad_cfg
        $error("kernal_params_loader: stream width must carry 1, 2, 4 or 8 whole parameters");
    end

    loader_state_t        state;
    logic [15:0]          chn_n_sub1;
    logic [16:0]          kcnt;
    logic                 cmd_acc;
    logic                 beat_acc;
    logic                 pk_in_vld;
    logic                 kern_vld;
    logic                 last_kern;
    logic [KERNAL_ELEM_N*W-1:0] kern_dat;

    assign cmd_acc   = s_cmd_valid && s_cmd_ready && (state == ST_IDLE);
    assign beat_acc  = s_axis_valid && s_axis_ready;
    assign pk_in_vld = beat_acc && (state == ST_LOAD);
    assign last_kern = kern_vld && (kcnt == {1'b0, chn_n_sub1});

    kernal_param_packer #(
        .param_width (W),
        .lane_n      (P)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cmd_acc),
        .in_vld   (pk_in_vld),
        .in_dat   (s_axis_data),
        .kern_vld (kern_vld),
        .kern_dat (kern_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            s_cmd_ready  <= 1'b0;
            s_axis_ready <= 1'b0;
            buffer_wen   <= 1'b0;
            buffer_waddr <= '0;
            buffer_din   <= '0;
            done         <= 1'b0;
            err_short    <= 1'b0;
            err_ovf      <= 1'b0;
            chn_n_sub1   <= '0;
            kcnt         <= '0;
        end else begin
            buffer_wen <= 1'b0;
            done       <= 1'b0;
            // Kernels past the buffer depth still advance the index but never write.
            if (kern_vld) begin
                buffer_wen   <= (kcnt < MAX_K);
                buffer_waddr <= kcnt[15:0];
                buffer_din   <= kern_dat;
                kcnt         <= kcnt + 17'd1;
                if (kcnt >= MAX_K) begin
                    err_ovf <= 1'b1;
                end
            end
            case (state)
                ST_IDLE: begin
                    s_cmd_ready <= 1'b1;
                    if (cmd_acc) begin
                        state        <= ST_LOAD;
                        s_cmd_ready  <= 1'b0;
                        s_axis_ready <= 1'b1;
                        chn_n_sub1   <= s_cmd_chn_n_sub1;
                        kcnt         <= '0;
                        err_short    <= 1'b0;
                        err_ovf      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (beat_acc) begin
                        if (s_axis_last) begin
                            state        <= ST_DONE;
                            s_axis_ready <= 1'b0;
                            done         <= 1'b1;
                            if (!last_kern) begin
                                err_short <= 1'b1;
                            end
                        end else if (last_kern) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (beat_acc && s_axis_last) begin
                        state        <= ST_DONE;
                        s_axis_ready <= 1'b0;
                        done         <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    s_cmd_ready <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kernal_params_loader.sv
// Directed bench: a W=16/P=4 loader and a W=8/P=8 loader (depth 2) share one command/stream driver.
module tb_kernal_params_loader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_cmd_valid;
    logic [15:0]  s_cmd_chn_n_sub1;
    logic [63:0]  s_axis_data;
    logic         s_axis_valid;
    logic         s_axis_last;

    logic         s_cmd_ready, s_axis_ready, buffer_wen, done, err_short, err_ovf;
    logic [15:0]  buffer_waddr;
    logic [143:0] buffer_din;

    logic         a_cmd_ready, a_axis_ready, a_wen, a_done, a_err_short, a_err_ovf;
    logic [15:0]  a_waddr;
    logic [71:0]  a_din;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [15:0]  q_addr[$];
    logic [143:0] q_din[$];
    logic [15:0]  qa_addr[$];
    logic [71:0]  qa_din[$];

    always #5 clk = ~clk;

    kernal_params_loader #(
        .kernal_param_data_width (16),
        .in_stream_width         (64),
        .max_feature_map_chn_n   (512),
        .simulation_delay        (1)
    ) u_dut (
        .clk (clk), .rst_n (rst_n),
        .s_cmd_valid (s_cmd_valid), .s_cmd_ready (s_cmd_ready), .s_cmd_chn_n_sub1 (s_cmd_chn_n_sub1),
        .s_axis_data (s_axis_data), .s_axis_valid (s_axis_valid), .s_axis_ready (s_axis_ready),
        .s_axis_last (s_axis_last),
        .buffer_wen (buffer_wen), .buffer_waddr (buffer_waddr), .buffer_din (buffer_din),
        .done (done), .err_short (err_short), .err_ovf (err_ovf)
    );

    kernal_params_loader #(
        .kernal_param_data_width (8),
        .in_stream_width         (64),
        .max_feature_map_chn_n   (2),
        .simulation_delay        (1)
    ) u_aux (
        .clk (clk), .rst_n (rst_n),
        .s_cmd_valid (s_cmd_valid), .s_cmd_ready (a_cmd_ready), .s_cmd_chn_n_sub1 (s_cmd_chn_n_sub1),
        .s_axis_data (s_axis_data), .s_axis_valid (s_axis_valid), .s_axis_ready (a_axis_ready),
        .s_axis_last (s_axis_last),
        .buffer_wen (a_wen), .buffer_waddr (a_waddr), .buffer_din (a_din),
        .done (a_done), .err_short (a_err_short), .err_ovf (a_err_ovf)
    );

    always @(negedge clk) begin
        if (buffer_wen) begin
            q_addr.push_back(buffer_waddr);
            q_din.push_back(buffer_din);
        end
        if (a_wen) begin
            qa_addr.push_back(a_waddr);
            qa_din.push_back(a_din);
        end
        if (done) done_cnt++;
    end

    function automatic logic [15:0] p16(input int base, input int i);
        return 16'(base + i);
    endfunction

    function automatic logic [63:0] beat16(input int base, input int b);
        logic [63:0] d;
        for (int k = 0; k < 4; k++) d[k*16 +: 16] = p16(base, 4*b + k);
        return d;
    endfunction

    function automatic logic [143:0] kern16(input int base, input int kn);
        logic [143:0] d;
        for (int e = 0; e < 9; e++) d[e*16 +: 16] = p16(base, 9*kn + e);
        return d;
    endfunction

    function automatic logic [63:0] beat8(input int base, input int b);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) d[k*8 +: 8] = 8'(base + 8*b + k);
        return d;
    endfunction

    function automatic logic [71:0] kern8(input int base, input int kn);
        logic [71:0] d;
        for (int e = 0; e < 9; e++) d[e*8 +: 8] = 8'(base + 9*kn + e);
        return d;
    endfunction

    // Byte j of a stream built from 16-bit params, as the 8-bit loader sees it.
    function automatic logic [71:0] kern8x(input int base, input int kn);
        logic [71:0] d;
        logic [15:0] v;
        int j;
        for (int e = 0; e < 9; e++) begin
            j = 9*kn + e;
            v = p16(base, j/2);
            d[e*8 +: 8] = (j % 2 == 0) ? v[7:0] : v[15:8];
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [15:0] n);
        s_cmd_valid = 1'b1;
        s_cmd_chn_n_sub1 = n;
        for (int i = 0; i < 20 && !s_cmd_ready; i++) tick();
        tick();
        s_cmd_valid = 1'b0;
        chk("axis_ready_after_cmd", s_axis_ready, 1);
    endtask

    task automatic beat(input logic [63:0] d, input logic last);
        s_axis_data = d;
        s_axis_valid = 1'b1;
        s_axis_last = last;
        tick();
        s_axis_valid = 1'b0;
        s_axis_last = 1'b0;
    endtask

    task automatic beat_gap(input logic [63:0] d, input logic last);
        for (int g = 0; g < 6 && $urandom_range(1, 0) == 1; g++) tick();
        beat(d, last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        s_cmd_valid = 1'b0;
        s_cmd_chn_n_sub1 = '0;
        s_axis_data = '0;
        s_axis_valid = 1'b0;
        s_axis_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", s_cmd_ready, 0);
        chk("rst_axis_ready", s_axis_ready, 0);
        chk("rst_wen", buffer_wen, 0);
        chk("rst_waddr", buffer_waddr, 0);
        chk("rst_din", buffer_din, 0);
        chk("rst_done", done, 0);
        chk("rst_errs", {err_short, err_ovf}, 0);
        rst_n = 1'b1;
        tick();
        chk("cmd_ready_after_rst", s_cmd_ready, 1);

        // Two kernels from 20 params, last on beat 5.
        cmd(16'd1);
        for (int b = 0; b < 3; b++) beat(beat16('h1000, b), 1'b0);
        chk("t1_wen0", buffer_wen, 1);
        chk("t1_addr0", buffer_waddr, 0);
        chk("t1_din0", buffer_din, kern16('h1000, 0));
        beat(beat16('h1000, 3), 1'b0);
        chk("t1_wen_idle", buffer_wen, 0);
        beat(beat16('h1000, 4), 1'b1);
        chk("t1_wen1", buffer_wen, 1);
        chk("t1_addr1", buffer_waddr, 1);
        chk("t1_din1", buffer_din, kern16('h1000, 1));
        chk("t1_done", done, 1);
        chk("t1_no_cmd_in_done", s_cmd_ready, 0);
        chk("t1_errs", {err_short, err_ovf}, 0);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_idle_ready", s_cmd_ready, 1);
        chk("t1_done_cnt", done_cnt, 1);

        // One kernel, then a drained beat carrying last.
        cmd(16'd0);
        for (int b = 0; b < 3; b++) beat(beat16('h2000, b), 1'b0);
        chk("t2_wen0", buffer_wen, 1);
        chk("t2_din0", buffer_din, kern16('h2000, 0));
        chk("t2_drain_ready", s_axis_ready, 1);
        beat(beat16('h2000, 3), 1'b1);
        chk("t2_drain_no_wen", buffer_wen, 0);
        chk("t2_done", done, 1);
        chk("t2_errs", {err_short, err_ovf}, 0);
        tick();

        // Stream ends short: 3 kernels asked, 20 params supplied.
        cmd(16'd2);
        for (int b = 0; b < 4; b++) beat(beat16('h3000, b), 1'b0);
        beat(beat16('h3000, 4), 1'b1);
        chk("t3_addr1", buffer_waddr, 1);
        chk("t3_din1", buffer_din, kern16('h3000, 1));
        chk("t3_done", done, 1);
        chk("t3_err_short", err_short, 1);
        tick();
        chk("t3_err_short_sticky", err_short, 1);

        // Depth-2 loader: third kernel suppressed, pad bytes in the last beat ignored.
        cmd(16'd2);
        chk("t4_err_short_cleared", err_short, 0);
        beat(beat8('h40, 0), 1'b0);
        beat(beat8('h40, 1), 1'b0);
        chk("t4_a_wen0", a_wen, 1);
        chk("t4_a_addr0", a_waddr, 0);
        chk("t4_a_din0", a_din, kern8('h40, 0));
        beat(beat8('h40, 2), 1'b0);
        chk("t4_a_addr1", a_waddr, 1);
        chk("t4_a_din1", a_din, kern8('h40, 1));
        beat(beat8('h40, 3), 1'b1);
        chk("t4_a_wen_ovf", a_wen, 0);
        chk("t4_a_err_ovf", a_err_ovf, 1);
        chk("t4_a_done", a_done, 1);
        chk("t4_a_err_short", a_err_short, 0);
        tick();

        // Random valid gaps: write sequence must match the gap-free packing.
        q_addr.delete(); q_din.delete(); qa_addr.delete(); qa_din.delete();
        cmd(16'd3);
        for (int b = 0; b < 9; b++) beat_gap(beat16('h5000, b), (b == 8));
        chk("t5_done", done, 1);
        chk("t5_errs", {err_short, err_ovf}, 0);
        tick();
        chk("t5_nwrites", q_addr.size(), 4);
        for (int k = 0; k < q_addr.size() && k < 4; k++) begin
            chk("t5_addr", q_addr[k], k);
            chk("t5_din", q_din[k], kern16('h5000, k));
        end
        chk("t5_a_nwrites", qa_addr.size(), 2);
        for (int k = 0; k < qa_addr.size() && k < 2; k++) begin
            chk("t5_a_addr", qa_addr[k], k);
            chk("t5_a_din", qa_din[k], kern8x('h5000, k));
        end
        chk("t5_a_err_ovf", a_err_ovf, 1);

        // Async reset with a partial kernel packed.
        cmd(16'd1);
        beat(beat16('h6000, 0), 1'b0);
        beat(beat16('h6000, 1), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_cmd_ready", s_cmd_ready, 0);
        chk("t6_axis_ready", s_axis_ready, 0);
        chk("t6_wen", buffer_wen, 0);
        chk("t6_waddr", buffer_waddr, 0);
        chk("t6_din", buffer_din, 0);
        chk("t6_done_err", {done, err_short, err_ovf}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        chk("t6_no_done_on_abort", done_cnt, 5);
        cmd(16'd0);
        for (int b = 0; b < 2; b++) beat(beat16('h7000, b), 1'b0);
        beat(beat16('h7000, 2), 1'b1);
        chk("t6_wen", buffer_wen, 1);
        chk("t6_addr0", buffer_waddr, 0);
        chk("t6_din_fresh", buffer_din, kern16('h7000, 0));
        chk("t6_done", done, 1);
        chk("t6_err_short", err_short, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
